quad_decoder_multi: RTL and testbench
=====================================

// Module: quad_decoder_multi
// PURPOSE
//  Multi-channel quadrature decoder for rotary encoders and knobs on the IO path.
//  Each channel glitch-filters its A/B inputs, decodes the Gray sequence at x1/x2/x4 resolution and keeps a signed position.
//  Emits a one-cycle step event with direction, and flags illegal A/B transitions.
//  Sits between the input synchronizers and the MMIO register block.
// PARAMETERS
//  NUM_CH        2   number of encoder channels
//  COUNT_W       16  position counter width (signed, two's complement)
//  FILTER_CYCLES 4   cycles an input must hold a new value before it is accepted; 0 = bypass
//  RESOLUTION    1   1 = A rising only, 2 = both A edges, 4 = every valid transition
//  VEL_WINDOW    1024 velocity sample window in cycles (used only with QUAD_VELOCITY_EN)
// PORTS
//  clk           in  1                clock
//  rst           in  1                synchronous reset, active-high
//  rotary_A      in  NUM_CH           A inputs, already synchronized to clk
//  rotary_B      in  NUM_CH           B inputs, already synchronized to clk
//  pos_clr       in  NUM_CH           per-channel synchronous position clear
//  err_clr       in  NUM_CH           per-channel sticky error clear
//  rotary_event  out NUM_CH           one-cycle pulse per counted step
//  rotary_left   out NUM_CH           direction of last counted step (1 = left), held between events
//  position      out NUM_CH*COUNT_W   packed signed positions, channel i at [i*COUNT_W +: COUNT_W]
//  err           out NUM_CH           sticky illegal-transition flag
//  velocity      out NUM_CH*COUNT_W   packed signed steps per VEL_WINDOW
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-high. On rst: all outputs 0, filtered A/B = 0, prev state = 00, filter and window counters 0.
//  - Filter: per input, counter increments while raw != filtered, clears when equal; at FILTER_CYCLES, filtered <= raw and counter clears.
//    FILTER_CYCLES=0: filtered = raw registered one cycle.
//  - State {A,B}: right = 00->10->11->01->00; left = 00->01->11->10->00. Prev state updates every cycle.
//  - Count qualification: x1 counts only A 0->1; x2 counts A 0->1 and 1->0; x4 counts all valid transitions.
//    x1 direction = B at the A edge: B=1 left, B=0 right.
//  - Latency: filtered transition in cycle n -> rotary_event high in n+1, for exactly one cycle.
//    Same cycle: rotary_left set, position updated (right +1, left -1).
//  - Position wraps modulo 2^COUNT_W: max+1 -> min, min-1 -> max. No saturation, no flag.
//  - Illegal transition (A and B both change): no event, no count, prev still updates, err set in n+1.
//  - err clears only via err_clr. err_clr in the same cycle as a new illegal transition: set wins.
//  - pos_clr in the same cycle as a counted step: position = 0, rotary_event still pulses, rotary_left still updates.
//  - Channels fully independent; simultaneous events on several channels are all reported in the same cycle.
//  - rst mid-motion: next transition is decoded from prev = 00. A spurious err after reset is acceptable and documented.
// CONFIGURATION
//  QUAD_VELOCITY_EN defined: per-channel signed step accumulator over VEL_WINDOW cycles.
//    At window end, velocity <= accumulator + this cycle's step, then accumulator <= 0. pos_clr does not affect it.
//    The window counter is shared by all channels and reset by rst.
//  Undefined: velocity port present but tied to 0; no accumulator or window logic synthesized.
// STRUCTURE
//  quad_defs.vh: localparams for state encodings (ST_00, ST_01, ST_11, ST_10) and RES_X1/RES_X2/RES_X4.
//    Also the step codes STEP_NONE / STEP_R / STEP_L / STEP_ERR.
//  Sub-module quad_channel: filter + decode + position (+ accumulator).
//    Instantiated NUM_CH times in a generate loop; the top holds the shared velocity window counter.
// TESTING
//  1 RESOLUTION=4, FILTER=0: one right cycle 00,10,11,01,00 on ch0 -> 4 events, rotary_left=0, position=4; ch1 unchanged.
//  2 RESOLUTION=1: full left cycle -> exactly 1 event, on A rising with B=1; rotary_left=1, position=-1 (0xFFFF at COUNT_W=16).
//  3 FILTER_CYCLES=4: 3-cycle A glitch -> no event. 4-cycle hold -> event 5 cycles after the raw edge.
//  4 Jump 00->11 -> err=1, no event, position unchanged. err_clr together with a second illegal jump -> err stays 1.
//  5 Preload position 0x7FFF, one right step -> 0x8000. pos_clr with a step -> position 0, event pulses.
//  6 QUAD_VELOCITY_EN, VEL_WINDOW=64: 10 right steps in a window -> velocity=10 at window end; next window idle -> 0.

Source files
------------

// File: rtl/quad_decoder_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quad_decoder_multi_pkg                                          |
// | Brief    : Shared state encodings, resolution codes, step codes and the    |
// |            Gray-sequence decode helpers for the quadrature decoder.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package quad_decoder_multi_pkg;

   // {A,B} state encodings
   localparam logic [1:0] ST_00 = 2'b00;
   localparam logic [1:0] ST_01 = 2'b01;
   localparam logic [1:0] ST_11 = 2'b11;
   localparam logic [1:0] ST_10 = 2'b10;

   // Counting resolution selectors
   localparam int RES_X1 = 1;
   localparam int RES_X2 = 2;
   localparam int RES_X4 = 4;

   // Classification of one prev->cur transition
   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_R    = 2'd1,
      STEP_L    = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

   // Right is 00->10->11->01->00, left is the reverse; a double change is illegal.
   function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
      step_e s;
      s = STEP_ERR;
      if (prev == cur) begin
         s = STEP_NONE;
      end else begin
         case (prev)
            ST_00:   if (cur == ST_10) s = STEP_R; else if (cur == ST_01) s = STEP_L;
            ST_10:   if (cur == ST_11) s = STEP_R; else if (cur == ST_00) s = STEP_L;
            ST_11:   if (cur == ST_01) s = STEP_R; else if (cur == ST_10) s = STEP_L;
            ST_01:   if (cur == ST_00) s = STEP_R; else if (cur == ST_11) s = STEP_L;
            default: s = STEP_ERR;
         endcase
      end
      return s;
   endfunction

   // Whether a valid step is counted at the chosen resolution (bit 1 is A).
   function automatic logic step_counts(input step_e s, input logic [1:0] prev,
                                        input logic [1:0] cur, input int res);
      logic valid;
      logic cnt;
      valid = (s == STEP_R) || (s == STEP_L);
      if (res == RES_X1)      cnt = valid && !prev[1] && cur[1];
      else if (res == RES_X2) cnt = valid && (prev[1] != cur[1]);
      else                    cnt = valid;
      return cnt;
   endfunction

endpackage
`default_nettype wire

// File: rtl/quad_decoder_multi_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quad_decoder_multi_channel                                      |
// | Brief    : One encoder channel: A/B glitch filter, Gray decode, signed     |
// |            wrapping position, sticky error, optional velocity accumulator |
// |            (enabled by QUAD_VELOCITY_EN).                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module quad_decoder_multi_channel
   import quad_decoder_multi_pkg::*;
#(
   parameter int COUNT_W       = 16,
   parameter int FILTER_CYCLES = 4,
   parameter int RESOLUTION    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               a_i,
   input  logic               b_i,
   input  logic               pos_clr_i,
   input  logic               err_clr_i,
`ifdef QUAD_VELOCITY_EN
   input  logic               win_end_i,
   output logic [COUNT_W-1:0] velocity_o,
`endif
   output logic               event_o,
   output logic               left_o,
   output logic [COUNT_W-1:0] position_o,
   output logic               err_o
);

   localparam logic [COUNT_W-1:0] c_one = COUNT_W'(1);

   logic [1:0] raw_ab;
   logic [1:0] filt_ab;

   assign raw_ab = {a_i, b_i};

   generate
      if (FILTER_CYCLES == 0) begin : g_bypass
         logic [1:0] filt_q;
         // Without filtering the inputs are simply registered once.
         always_ff @(posedge clk) begin
            if (rst) filt_q <= 2'b00;
            else     filt_q <= raw_ab;
         end
         assign filt_ab = filt_q;
      end else begin : g_filter
         localparam int CW = $clog2(FILTER_CYCLES + 1);
         for (genvar k = 0; k < 2; k++) begin : g_bit
            logic          bit_q;
            logic [CW-1:0] cnt_q;
            // Accept a new level only after it has differed for FILTER_CYCLES cycles.
            always_ff @(posedge clk) begin
               if (rst) begin
                  bit_q <= 1'b0;
                  cnt_q <= '0;
               end else if (raw_ab[k] == bit_q) begin
                  cnt_q <= '0;
               end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                  bit_q <= raw_ab[k];
                  cnt_q <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            assign filt_ab[k] = bit_q;
         end
      end
   endgenerate

   logic [1:0]         prev_q;
   logic               event_q, event_d;
   logic               left_q, left_d;
   logic [COUNT_W-1:0] pos_q, pos_d;
   logic               err_q, err_d;
   step_e              step;
   logic               counted;
   logic [COUNT_W-1:0] step_val;
`ifdef QUAD_VELOCITY_EN
   logic [COUNT_W-1:0] acc_q, acc_d;
   logic [COUNT_W-1:0] vel_q, vel_d;
`endif

   // Classify the filtered transition and derive next position, direction and error.
   always_comb begin
      step     = decode_step(prev_q, filt_ab);
      counted  = step_counts(step, prev_q, filt_ab, RESOLUTION);
      step_val = counted ? ((step == STEP_L) ? '1 : c_one) : '0;
      event_d  = counted;
      left_d   = counted ? (step == STEP_L) : left_q;
      pos_d    = pos_clr_i ? '0 : (pos_q + step_val);
      err_d    = (step == STEP_ERR) ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
`ifdef QUAD_VELOCITY_EN
      if (win_end_i) begin
         vel_d = acc_q + step_val;
         acc_d = '0;
      end else begin
         vel_d = vel_q;
         acc_d = acc_q + step_val;
      end
`endif
   end

   // Channel state registers; prev follows the filtered inputs every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= ST_00;
         event_q <= 1'b0;
         left_q  <= 1'b0;
         pos_q   <= '0;
         err_q   <= 1'b0;
`ifdef QUAD_VELOCITY_EN
         acc_q   <= '0;
         vel_q   <= '0;
`endif
      end else begin
         prev_q  <= filt_ab;
         event_q <= event_d;
         left_q  <= left_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
`ifdef QUAD_VELOCITY_EN
         acc_q   <= acc_d;
         vel_q   <= vel_d;
`endif
      end
   end

   assign event_o    = event_q;
   assign left_o     = left_q;
   assign position_o = pos_q;
   assign err_o      = err_q;
`ifdef QUAD_VELOCITY_EN
   assign velocity_o = vel_q;
`endif

endmodule
`default_nettype wire

// File: rtl/quad_decoder_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : quad_decoder_multi                                              |
// | Brief    : Multi-channel quadrature decoder. Replicates one channel per    |
// |            encoder and, with QUAD_VELOCITY_EN defined, owns the shared     |
// |            velocity window counter. Without it velocity is tied to 0.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module quad_decoder_multi
   import quad_decoder_multi_pkg::*;
#(
   parameter int NUM_CH        = 2,
   parameter int COUNT_W       = 16,
   parameter int FILTER_CYCLES = 4,
   parameter int RESOLUTION    = 1,
   parameter int VEL_WINDOW    = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         rotary_A,
   input  logic [NUM_CH-1:0]         rotary_B,
   input  logic [NUM_CH-1:0]         pos_clr,
   input  logic [NUM_CH-1:0]         err_clr,
   output logic [NUM_CH-1:0]         rotary_event,
   output logic [NUM_CH-1:0]         rotary_left,
   output logic [NUM_CH*COUNT_W-1:0] position,
   output logic [NUM_CH-1:0]         err,
   output logic [NUM_CH*COUNT_W-1:0] velocity
);

`ifdef QUAD_VELOCITY_EN
   localparam int WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;

   logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
   logic             win_end;

   // Window end on the last cycle of each VEL_WINDOW period.
   always_comb begin
      win_end   = (win_cnt_q == WIN_W'(VEL_WINDOW - 1));
      win_cnt_d = win_end ? '0 : (win_cnt_q + WIN_W'(1));
   end

   // Shared free-running window counter.
   always_ff @(posedge clk) begin
      if (rst) win_cnt_q <= '0;
      else     win_cnt_q <= win_cnt_d;
   end
`else
   assign velocity = '0;
`endif

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         quad_decoder_multi_channel #(
            .COUNT_W       (COUNT_W),
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESOLUTION    (RESOLUTION)
         ) u_channel (
            .clk        (clk),
            .rst        (rst),
            .a_i        (rotary_A[i]),
            .b_i        (rotary_B[i]),
            .pos_clr_i  (pos_clr[i]),
            .err_clr_i  (err_clr[i]),
`ifdef QUAD_VELOCITY_EN
            .win_end_i  (win_end),
            .velocity_o (velocity[i*COUNT_W +: COUNT_W]),
`endif
            .event_o    (rotary_event[i]),
            .left_o     (rotary_left[i]),
            .position_o (position[i*COUNT_W +: COUNT_W]),
            .err_o      (err[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_quad_decoder_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_quad_decoder_multi                                           |
// | Brief    : Self-checking bench for quad_decoder_multi: directed tables,    |
// |            multi-cycle corner sequences and a randomized x4 run against   |
// |            a Gray-index reference model. QUAD_VELOCITY_EN adds a velocity |
// |            window check.                                                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_quad_decoder_multi;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // x4, no filter, two channels
   logic [1:0]  x4_a, x4_b, x4_pc, x4_ec, x4_ev, x4_lf, x4_er;
   logic [31:0] x4_pos, x4_vel;
   // x1, 4-cycle filter, two channels
   logic [1:0]  x1_a, x1_b, x1_pc, x1_ec, x1_ev, x1_lf, x1_er;
   logic [31:0] x1_pos, x1_vel;
   // x4, 4-bit counter, one channel (wrap checks)
   logic        w_a, w_b, w_pc, w_ec, w_ev, w_lf, w_er;
   logic [3:0]  w_pos, w_vel;

   quad_decoder_multi #(.NUM_CH(2), .COUNT_W(16), .FILTER_CYCLES(0), .RESOLUTION(4), .VEL_WINDOW(64)) u_x4 (
      .clk(clk), .rst(rst), .rotary_A(x4_a), .rotary_B(x4_b), .pos_clr(x4_pc), .err_clr(x4_ec),
      .rotary_event(x4_ev), .rotary_left(x4_lf), .position(x4_pos), .err(x4_er), .velocity(x4_vel));

   quad_decoder_multi #(.NUM_CH(2), .COUNT_W(16), .FILTER_CYCLES(4), .RESOLUTION(1), .VEL_WINDOW(64)) u_x1 (
      .clk(clk), .rst(rst), .rotary_A(x1_a), .rotary_B(x1_b), .pos_clr(x1_pc), .err_clr(x1_ec),
      .rotary_event(x1_ev), .rotary_left(x1_lf), .position(x1_pos), .err(x1_er), .velocity(x1_vel));

   quad_decoder_multi #(.NUM_CH(1), .COUNT_W(4), .FILTER_CYCLES(0), .RESOLUTION(4), .VEL_WINDOW(64)) u_w (
      .clk(clk), .rst(rst), .rotary_A(w_a), .rotary_B(w_b), .pos_clr(w_pc), .err_clr(w_ec),
      .rotary_event(w_ev), .rotary_left(w_lf), .position(w_pos), .err(w_er), .velocity(w_vel));

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  ab;
      logic        ev;
      logic        lf;
      logic [15:0] pos;
      logic        er;
   } vec_t;

   vec_t        tbl [8];
   logic [1:0]  gray [4];
   int          widx;
   int          ev_cnt, ev_phase, first;
   logic [1:0]  cur [2], h1 [2], h2 [2];
   logic [15:0] mpos [2];
   logic        mev [2], mlf [2], mer [2];
   int          d, gi, r;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Position of an {A,B} value around the right-turning Gray cycle.
   function automatic int gidx(input logic [1:0] ab);
      case (ab)
         2'b00:   return 0;
         2'b10:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic drive_x4(input int ch, input logic [1:0] ab);
      x4_a[ch] = ab[1];
      x4_b[ch] = ab[0];
   endtask

   task automatic w_step(input int dir);
      widx = (widx + dir + 4) % 4;
      w_a  = gray[widx][1];
      w_b  = gray[widx][0];
      tick();
      tick();
   endtask

   initial begin
      gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
      tbl[0] = '{2'b10, 1'b1, 1'b0, 16'd1, 1'b0};
      tbl[1] = '{2'b11, 1'b1, 1'b0, 16'd2, 1'b0};
      tbl[2] = '{2'b01, 1'b1, 1'b0, 16'd3, 1'b0};
      tbl[3] = '{2'b00, 1'b1, 1'b0, 16'd4, 1'b0};
      tbl[4] = '{2'b01, 1'b1, 1'b1, 16'd3, 1'b0};
      tbl[5] = '{2'b00, 1'b1, 1'b0, 16'd4, 1'b0};
      tbl[6] = '{2'b11, 1'b0, 1'b0, 16'd4, 1'b1};
      tbl[7] = '{2'b11, 1'b0, 1'b0, 16'd4, 1'b1};

      rst = 1'b1;
      x4_a = '0; x4_b = '0; x4_pc = '0; x4_ec = '0;
      x1_a = '0; x1_b = '0; x1_pc = '0; x1_ec = '0;
      w_a = 1'b0; w_b = 1'b0; w_pc = 1'b0; w_ec = 1'b0;
      widx = 0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_event", x4_ev, 0);
      chk("rst_left", x4_lf, 0);
      chk("rst_pos", x4_pos, 0);
      chk("rst_err", x4_er, 0);
      chk("rst_vel", x4_vel, 0);
      chk("rst_x1_pos", x1_pos, 0);

      // x4 right cycle, reversal, illegal jump on ch0
      for (int i = 0; i < 8; i++) begin
         drive_x4(0, tbl[i].ab);
         tick();
         tick();
         chk($sformatf("tbl%0d_event", i), x4_ev[0], tbl[i].ev);
         chk($sformatf("tbl%0d_left", i), x4_lf[0], tbl[i].lf);
         chk($sformatf("tbl%0d_pos", i), x4_pos[15:0], tbl[i].pos);
         chk($sformatf("tbl%0d_err", i), x4_er[0], tbl[i].er);
      end
      chk("ch1_pos_untouched", x4_pos[31:16], 0);
      chk("ch1_err_untouched", x4_er[1], 0);

      // err_clr clears; err_clr together with an illegal jump keeps err set
      x4_ec[0] = 1'b1; tick(); x4_ec[0] = 1'b0;
      chk("err_clr", x4_er[0], 0);
      drive_x4(0, 2'b00); tick();
      x4_ec[0] = 1'b1; tick(); x4_ec[0] = 1'b0;
      chk("err_set_wins", x4_er[0], 1);
      chk("err_no_event", x4_ev[0], 0);
      chk("err_pos_hold", x4_pos[15:0], 16'd4);
      x4_ec[0] = 1'b1; tick(); x4_ec[0] = 1'b0;
      chk("err_clr2", x4_er[0], 0);

      // pos_clr coinciding with a counted step
      drive_x4(0, 2'b10); tick();
      x4_pc[0] = 1'b1; tick(); x4_pc[0] = 1'b0;
      chk("pclr_event", x4_ev[0], 1);
      chk("pclr_pos", x4_pos[15:0], 0);
      chk("pclr_left", x4_lf[0], 0);
      tick();
      chk("event_one_cycle", x4_ev[0], 0);
      drive_x4(0, 2'b00); tick(); tick();
      chk("left_step_pos", x4_pos[15:0], 16'hFFFF);
      chk("left_step_dir", x4_lf[0], 1);
      tick(); tick(); tick();
      chk("left_held", x4_lf[0], 1);
      chk("idle_no_event", x4_ev[0], 0);

      // x1: full left cycle gives one event, on the A rise with B=1
      ev_cnt = 0; ev_phase = -1;
      for (int p = 0; p < 4; p++) begin
         x1_a[0] = gray[(4 - p - 1) % 4 == 0 ? 0 : 4 - p - 1][1];
         x1_b[0] = gray[(4 - p - 1) % 4 == 0 ? 0 : 4 - p - 1][0];
         for (int t = 0; t < 8; t++) begin
            tick();
            if (x1_ev[0]) begin
               ev_cnt++;
               ev_phase = p;
            end
         end
      end
      chk("x1_event_count", ev_cnt, 1);
      chk("x1_event_phase", ev_phase, 1);
      chk("x1_left", x1_lf[0], 1);
      chk("x1_pos", x1_pos[15:0], 16'hFFFF);

      // Filter: 3-cycle glitch rejected, 4-cycle hold accepted 5 cycles after the edge
      ev_cnt = 0;
      x1_a[1] = 1'b1; tick(); tick(); tick();
      x1_a[1] = 1'b0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (x1_ev[1]) ev_cnt++;
      end
      chk("glitch_rejected", ev_cnt, 0);
      first = 0; ev_cnt = 0;
      x1_a[1] = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         tick();
         if (x1_ev[1]) begin
            ev_cnt++;
            if (first == 0) first = t;
         end
      end
      chk("filter_latency", first, 5);
      chk("filter_events", ev_cnt, 1);
      chk("filter_pos", x1_pos[31:16], 16'd1);
      chk("filter_left", x1_lf[1], 0);
      chk("x1_ch0_untouched", x1_pos[15:0], 16'hFFFF);

      // Wrap on a 4-bit counter
      w_step(-1);
      chk("wrap_0_minus_1", w_pos, 4'hF);
      w_step(1);
      chk("wrap_back_0", w_pos, 4'h0);
      for (int k = 0; k < 7; k++) w_step(1);
      chk("wrap_max", w_pos, 4'h7);
      w_step(1);
      chk("wrap_max_plus_1", w_pos, 4'h8);
      w_step(-1);
      chk("wrap_min_minus_1", w_pos, 4'h7);

`ifdef QUAD_VELOCITY_EN
      // Ten right steps in the first window, then an idle window
      x4_a = '0; x4_b = '0; x4_pc = '0; x4_ec = '0;
      rst = 1'b1; tick(); rst = 1'b0;
      gi = 0;
      for (int k = 0; k < 10; k++) begin
         gi = (gi + 1) % 4;
         drive_x4(0, gray[gi]);
         tick();
         tick();
      end
      for (int t = 20; t < 70; t++) tick();
      chk("vel_window1", x4_vel[15:0], 16'd10);
      chk("vel_ch1_idle", x4_vel[31:16], 0);
      for (int t = 70; t < 140; t++) tick();
      chk("vel_window2", x4_vel[15:0], 0);
`endif

      // Randomized x4 run against the Gray-index model
      x4_a = '0; x4_b = '0; x4_pc = '0; x4_ec = '0;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         cur[c] = 2'b00; h1[c] = 2'b00; h2[c] = 2'b00;
         mpos[c] = '0; mev[c] = 1'b0; mlf[c] = 1'b0; mer[c] = 1'b0;
      end
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int c = 0; c < 2; c++) begin
            r  = int'($urandom_range(0, 9));
            gi = gidx(cur[c]);
            if (r < 3)       gi = (gi + 1) % 4;
            else if (r < 6)  gi = (gi + 3) % 4;
            else if (r == 6) gi = (gi + 2) % 4;
            cur[c] = gray[gi];
            drive_x4(c, cur[c]);
            x4_pc[c] = ($urandom_range(0, 19) == 0);
            x4_ec[c] = ($urandom_range(0, 9) == 0);
         end
         tick();
         for (int c = 0; c < 2; c++) begin
            d = (gidx(h1[c]) - gidx(h2[c]) + 4) % 4;
            mev[c] = (d == 1) || (d == 3);
            if (mev[c]) mlf[c] = (d == 3);
            if (x4_pc[c])       mpos[c] = '0;
            else if (d == 1)    mpos[c] = mpos[c] + 16'd1;
            else if (d == 3)    mpos[c] = mpos[c] - 16'd1;
            if (d == 2)         mer[c] = 1'b1;
            else if (x4_ec[c])  mer[c] = 1'b0;
            chk($sformatf("rnd%0d_ch%0d_event", cyc, c), x4_ev[c], mev[c]);
            chk($sformatf("rnd%0d_ch%0d_left", cyc, c), x4_lf[c], mlf[c]);
            chk($sformatf("rnd%0d_ch%0d_pos", cyc, c), x4_pos[c*16 +: 16], mpos[c]);
            chk($sformatf("rnd%0d_ch%0d_err", cyc, c), x4_er[c], mer[c]);
            h2[c] = h1[c];
            h1[c] = cur[c];
         end
      end
      x4_pc = '0; x4_ec = '0;

`ifndef QUAD_VELOCITY_EN
      chk("vel_tied_zero", x4_vel, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
